// File: rtl/alu_pkg.sv
// Shared definitions for the ALU control decoder and the execute stage:
// op codes, FSM state encoding and the default datapath width.
package alu_pkg;

  localparam int ALU_WIDTH = 32;

  localparam logic [3:0] ALU_AND = 4'd0;
  localparam logic [3:0] ALU_OR  = 4'd1;
  localparam logic [3:0] ALU_ADD = 4'd2;
  localparam logic [3:0] ALU_SUB = 4'd3;
  localparam logic [3:0] ALU_SLL = 4'd4;
  localparam logic [3:0] ALU_SLT = 4'd5;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } alu_state_e;

  function automatic logic op_legal(input logic [3:0] op);
    return (op <= ALU_SLT);
  endfunction

endpackage

// File: rtl/alu_shift_unit.sv
// Shift engine for sll. ALU_ITER_SHIFT_EN selects the 1-bit-per-cycle
// iterative shifter; otherwise a combinational barrel shift is used.
module alu_shift_unit
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             step,
  input  logic [WIDTH-1:0] src,
  input  logic [4:0]       shamt,
  output logic [WIDTH-1:0] imm_result,
  output logic [WIDTH-1:0] iter_result,
  output logic             done
);

`ifdef ALU_ITER_SHIFT_EN
  logic [WIDTH-1:0] sreg_r;
  logic [4:0]       cnt_r;

  // Shift register and remaining-step counter
  always_ff @(posedge clk) begin
    if (rst) begin
      sreg_r <= '0;
      cnt_r  <= 5'd0;
    end else if (load) begin
      sreg_r <= src;
      cnt_r  <= shamt;
    end else if (step) begin
      sreg_r <= {sreg_r[WIDTH-2:0], 1'b0};
      cnt_r  <= cnt_r - 5'd1;
    end else begin
      sreg_r <= sreg_r;
      cnt_r  <= cnt_r;
    end
  end

  // Single-cycle path is only taken for shamt == 0, so the operand passes through.
  assign imm_result  = src;
  assign iter_result = {sreg_r[WIDTH-2:0], 1'b0};
  assign done        = (cnt_r == 5'd1);
`else
  logic unused_s;

  assign imm_result  = src << shamt;
  assign iter_result = '0;
  assign done        = 1'b1;
  assign unused_s    = ^{clk, rst, load, step};
`endif

endmodule

// File: rtl/alu_execute.sv
// MIPS execute stage: ALU plus EX/MEM result registers with valid/ready toward ID/EX.
// ALU_ITER_SHIFT_EN enables the multi-cycle iterative sll.
module alu_execute
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  input  logic [4:0]       shamt,
  input  logic [4:0]       dst_reg,
  input  logic             reg_write,
  input  logic             flush,
  output logic             out_valid,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic [4:0]       out_dst_reg,
  output logic             out_reg_write,
  output logic             illegal_op
);

`ifdef ALU_ITER_SHIFT_EN
  localparam logic ITER_EN = 1'b1;
`else
  localparam logic ITER_EN = 1'b0;
`endif

  alu_state_e       state_r, next_state_s;
  logic [WIDTH-1:0] alu_res_s, shift_imm_s, shift_iter_s;
  logic             legal_s, shift_done_s, load_s, step_s;
  logic [4:0]       pend_dst_r, pend_dst_nxt_s, dst_nxt_s;
  logic             pend_rw_r, pend_rw_nxt_s;
  logic             valid_nxt_s, zero_nxt_s, rw_nxt_s, ill_nxt_s;
  logic [WIDTH-1:0] result_nxt_s;

  alu_shift_unit #(.WIDTH(WIDTH)) u_shift (
    .clk         (clk),
    .rst         (rst),
    .load        (load_s),
    .step        (step_s),
    .src         (src_b),
    .shamt       (shamt),
    .imm_result  (shift_imm_s),
    .iter_result (shift_iter_s),
    .done        (shift_done_s)
  );

  assign in_ready = (state_r == ST_IDLE);

  // Single-cycle ALU result for the operation presented on the inputs
  always_comb begin
    alu_res_s = '0;
    legal_s   = op_legal(op);
    case (op)
      ALU_AND: alu_res_s = src_a & src_b;
      ALU_OR:  alu_res_s = src_a | src_b;
      ALU_ADD: alu_res_s = src_a + src_b;
      ALU_SUB: alu_res_s = src_a - src_b;
      ALU_SLL: alu_res_s = shift_imm_s;
      ALU_SLT: alu_res_s = {{(WIDTH-1){1'b0}}, ($signed(src_a) < $signed(src_b))};
      default: alu_res_s = '0;
    endcase
  end

  // Next state and next EX/MEM register contents; flush beats accept and completion
  always_comb begin
    next_state_s   = state_r;
    load_s         = 1'b0;
    step_s         = 1'b0;
    valid_nxt_s    = 1'b0;
    result_nxt_s   = result;
    zero_nxt_s     = zero;
    dst_nxt_s      = out_dst_reg;
    rw_nxt_s       = out_reg_write;
    ill_nxt_s      = illegal_op;
    pend_dst_nxt_s = pend_dst_r;
    pend_rw_nxt_s  = pend_rw_r;
    case (state_r)
      ST_IDLE: begin
        if (in_valid && !flush) begin
          if (ITER_EN && (op == ALU_SLL) && (shamt != 5'd0)) begin
            load_s         = 1'b1;
            pend_dst_nxt_s = dst_reg;
            pend_rw_nxt_s  = reg_write;
            next_state_s   = ST_SHIFT;
          end else begin
            valid_nxt_s  = 1'b1;
            result_nxt_s = alu_res_s;
            zero_nxt_s   = (alu_res_s == '0);
            dst_nxt_s    = dst_reg;
            rw_nxt_s     = reg_write & legal_s;
            ill_nxt_s    = ~legal_s;
          end
        end else begin
          next_state_s = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        if (flush) begin
          next_state_s = ST_IDLE;
        end else if (shift_done_s) begin
          valid_nxt_s  = 1'b1;
          result_nxt_s = shift_iter_s;
          zero_nxt_s   = (shift_iter_s == '0);
          dst_nxt_s    = pend_dst_r;
          rw_nxt_s     = pend_rw_r;
          ill_nxt_s    = 1'b0;
          next_state_s = ST_IDLE;
        end else begin
          step_s = 1'b1;
        end
      end
      default: next_state_s = ST_IDLE;
    endcase
  end

  // FSM state, pending shift tag and EX/MEM output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r       <= ST_IDLE;
      out_valid     <= 1'b0;
      result        <= '0;
      zero          <= 1'b1;
      out_dst_reg   <= 5'd0;
      out_reg_write <= 1'b0;
      illegal_op    <= 1'b0;
      pend_dst_r    <= 5'd0;
      pend_rw_r     <= 1'b0;
    end else begin
      state_r       <= next_state_s;
      out_valid     <= valid_nxt_s;
      result        <= result_nxt_s;
      zero          <= zero_nxt_s;
      out_dst_reg   <= dst_nxt_s;
      out_reg_write <= rw_nxt_s;
      illegal_op    <= ill_nxt_s;
      pend_dst_r    <= pend_dst_nxt_s;
      pend_rw_r     <= pend_rw_nxt_s;
    end
  end

endmodule

// File: tb/tb_alu_execute.sv
// Self-checking bench for alu_execute: directed cases plus randomized traffic
// compared every cycle against a latency-counting reference model.
module tb_alu_execute;

  localparam int W = 32;
`ifdef ALU_ITER_SHIFT_EN
  localparam bit ITER = 1'b1;
`else
  localparam bit ITER = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst, in_valid, in_ready, flush, reg_write;
  logic         out_valid, zero, out_reg_write, illegal_op;
  logic [3:0]   op;
  logic [W-1:0] src_a, src_b, result;
  logic [4:0]   shamt, dst_reg, out_dst_reg;

  int checks = 0;
  int passes = 0;
  bit chk_en = 1'b0;

  // reference model state: expected outputs and cycles left on an iterative shift
  logic         m_valid, m_zero, m_rw, m_ill, m_ready;
  logic [W-1:0] m_result, p_result;
  logic [4:0]   m_dst, p_dst;
  logic         p_rw;
  int           remaining = 0;

  always #5 clk = ~clk;

  alu_execute #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .src_a(src_a), .src_b(src_b), .shamt(shamt),
    .dst_reg(dst_reg), .reg_write(reg_write), .flush(flush),
    .out_valid(out_valid), .result(result), .zero(zero),
    .out_dst_reg(out_dst_reg), .out_reg_write(out_reg_write), .illegal_op(illegal_op)
  );

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] want);
    checks++;
    if (act === want) passes++;
    else $display("FAIL %s: got 0x%h, expected 0x%h at %0t", name, act, want, $time);
  endtask

  function automatic logic [W-1:0] ref_alu(input logic [3:0] o, input logic [W-1:0] a,
                                           input logic [W-1:0] b, input logic [4:0] s);
    case (o)
      4'd0: return a & b;
      4'd1: return a | b;
      4'd2: return a + b;
      4'd3: return a - b;
      4'd4: return b << s;
      4'd5: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      default: return 32'd0;
    endcase
  endfunction

  task automatic complete(input logic [W-1:0] r, input logic [4:0] d, input logic rw, input logic ill);
    m_valid  = 1'b1;
    m_result = r;
    m_zero   = (r == 32'd0);
    m_dst    = d;
    m_rw     = rw & ~ill;
    m_ill    = ill;
  endtask

  // model: one step per clock edge, from the operation rules and latencies
  always @(posedge clk) begin
    m_valid = 1'b0;
    if (rst) begin
      m_result = 32'd0; m_zero = 1'b1; m_dst = 5'd0; m_rw = 1'b0; m_ill = 1'b0;
      remaining = 0;
    end else if (remaining > 0) begin
      if (flush) remaining = 0;
      else begin
        remaining--;
        if (remaining == 0) complete(p_result, p_dst, p_rw, 1'b0);
      end
    end else if (in_valid && !flush) begin
      if (ITER && op == 4'd4 && shamt != 5'd0) begin
        remaining = int'(shamt);
        p_result  = ref_alu(op, src_a, src_b, shamt);
        p_dst     = dst_reg;
        p_rw      = reg_write;
      end else begin
        complete(ref_alu(op, src_a, src_b, shamt), dst_reg, reg_write, op > 4'd5);
      end
    end
    m_ready = (remaining == 0);
  end

  // compare every cycle away from the active edge
  always @(negedge clk) begin
    if (chk_en) begin
      check("out_valid", {31'd0, out_valid}, {31'd0, m_valid});
      check("in_ready", {31'd0, in_ready}, {31'd0, m_ready});
      check("result", result, m_result);
      check("zero", {31'd0, zero}, {31'd0, m_zero});
      check("out_dst_reg", {27'd0, out_dst_reg}, {27'd0, m_dst});
      check("out_reg_write", {31'd0, out_reg_write}, {31'd0, m_rw});
      check("illegal_op", {31'd0, illegal_op}, {31'd0, m_ill});
    end
  end

  // present one operation, hold it for one edge, return at the next negedge
  task automatic issue(input logic [3:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [4:0] s, input logic [4:0] d, input logic rw);
    op = o; src_a = a; src_b = b; shamt = s; dst_reg = d; reg_write = rw;
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    int low, pulses;
    logic [W-1:0] cap;
    rst = 1'b1; in_valid = 1'b0; flush = 1'b0; op = 4'd0; src_a = '0; src_b = '0;
    shamt = 5'd0; dst_reg = 5'd0; reg_write = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    chk_en = 1'b1;
    @(negedge clk);
    check("rst_valid", {31'd0, out_valid}, 32'd0);
    check("rst_zero", {31'd0, zero}, 32'd1);
    check("rst_ready", {31'd0, in_ready}, 32'd1);
    check("rst_result", result, 32'd0);

    issue(4'd2, 32'd5, 32'd7, 5'd0, 5'd3, 1'b1);
    check("add_valid", {31'd0, out_valid}, 32'd1);
    check("add_result", result, 32'd12);
    check("add_zero", {31'd0, zero}, 32'd0);
    check("add_dst", {27'd0, out_dst_reg}, 32'd3);

    issue(4'd3, 32'd9, 32'd9, 5'd0, 5'd4, 1'b1);
    check("sub_result", result, 32'd0);
    check("sub_zero", {31'd0, zero}, 32'd1);

    issue(4'd5, 32'hFFFF_FFFF, 32'd1, 5'd0, 5'd5, 1'b1);
    check("slt_result", result, 32'd1);

    issue(4'd9, 32'd3, 32'd4, 5'd0, 5'd6, 1'b1);
    check("ill_flag", {31'd0, illegal_op}, 32'd1);
    check("ill_rw", {31'd0, out_reg_write}, 32'd0);
    check("ill_result", result, 32'd0);
    check("ill_valid", {31'd0, out_valid}, 32'd1);

    issue(4'd4, 32'd0, 32'h1, 5'd4, 5'd7, 1'b1);
    low = 0; pulses = 0; cap = '0;
    for (int i = 0; i < 8; i++) begin
      if (i > 0) @(negedge clk);
      if (!in_ready) low++;
      if (out_valid) begin pulses++; cap = result; end
    end
    check("sll4_ready_low", 32'(low), ITER ? 32'd4 : 32'd0);
    check("sll4_pulses", 32'(pulses), 32'd1);
    check("sll4_result", cap, 32'h10);

    issue(4'd4, 32'd0, 32'hABCD, 5'd0, 5'd8, 1'b1);
    check("sll0_valid", {31'd0, out_valid}, 32'd1);
    check("sll0_result", result, 32'hABCD);

    issue(4'd4, 32'd0, 32'h1, 5'd31, 5'd9, 1'b1);
    pulses = 0;
    for (int i = 0; i < 40; i++) begin
      if (i > 0) @(negedge clk);
      if (out_valid) pulses++;
      if (i == 3) check("flush_ready", {31'd0, in_ready}, 32'd1);
      flush = (i == 2);
    end
    check("flush_pulses", 32'(pulses), ITER ? 32'd0 : 32'd1);

    issue(4'd0, 32'h0000_F0F0, 32'h0000_00FF, 5'd0, 5'd10, 1'b1);
    check("and_result", result, 32'h0000_00F0);

    issue(4'd4, 32'd0, 32'h3, 5'd20, 5'd11, 1'b1);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("mid_rst_valid", {31'd0, out_valid}, 32'd0);
    check("mid_rst_result", result, 32'd0);
    check("mid_rst_zero", {31'd0, zero}, 32'd1);
    check("mid_rst_dst", {27'd0, out_dst_reg}, 32'd0);
    check("mid_rst_rw", {31'd0, out_reg_write}, 32'd0);
    check("mid_rst_ill", {31'd0, illegal_op}, 32'd0);
    check("mid_rst_ready", {31'd0, in_ready}, 32'd1);
    pulses = 0;
    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      if (out_valid) pulses++;
    end
    check("mid_rst_stale", 32'(pulses), 32'd0);

    for (int i = 0; i < 600; i++) begin
      in_valid  = ($urandom_range(0, 9) < 7);
      op        = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 5));
      shamt     = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 5));
      src_a     = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : $urandom();
      src_b     = ($urandom_range(0, 4) == 0) ? src_a : $urandom();
      dst_reg   = 5'($urandom_range(0, 31));
      reg_write = 1'($urandom_range(0, 1));
      flush     = ($urandom_range(0, 19) == 0);
      rst       = ($urandom_range(0, 99) == 0);
      @(negedge clk);
    end
    in_valid = 1'b0; flush = 1'b0; rst = 1'b0;
    repeat (40) @(negedge clk);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/alu_execute.md
# alu_execute

Execute-stage block of the pipelined MIPS core. Consumes the 4-bit ALU operation code from the ALU control decoder together with the ID/EX operands, computes the result, and registers it with its destination tag into the EX/MEM boundary. Provides a valid/ready handshake toward the ID/EX stage so that a multi-cycle shift can stall the front end, and accepts a flush from hazard control.

## Interface
- WIDTH, 32: datapath width in bits.
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous reset, active-high.
- in_valid  input  1  operation presented this cycle.
- in_ready  output  1  block can accept an operation this cycle.
- op  input  4  0 and, 1 or, 2 add, 3 sub, 4 sll, 5 slt; 6–15 illegal.
- src_a  input  WIDTH  rs operand.
- src_b  input  WIDTH  rt operand or sign-extended immediate.
- shamt  input  5  shift amount for sll.
- dst_reg  input  5  destination register tag.
- reg_write  input  1  write-back enable carried with the operation.
- flush  input  1  kill the accepted or in-flight operation.
- out_valid  output  1  result registers hold a completed operation for one cycle.
- result  output  WIDTH  ALU result.
- zero  output  1  result == 0 (beq uses op 3).
- out_dst_reg  output  5  registered dst_reg.
- out_reg_write  output  1  registered reg_write, forced 0 on illegal op.
- illegal_op  output  1  completed operation had an op of 6–15.

## Operation
- Accept occurs on a cycle with in_valid && in_ready && !flush.
- and/or: bitwise. add/sub: modulo 2^WIDTH; no overflow trap, no carry output. slt: signed compare, result 1 or 0, zero-extended. sll: src_b << shamt; bits shifted out are lost, zeros shifted in.
- Illegal op: result = 0, zero = 1, illegal_op = 1, out_reg_write = 0, out_valid = 1.
- The FSM has two states, IDLE and SHIFT. Only sll with shamt != 0 enters SHIFT, and only with ALU_ITER_SHIFT_EN defined. Every other case stays in IDLE.
- IDLE: in_ready = 1. On accept, either complete in one cycle or load the shift register and counter, then go to SHIFT.
- SHIFT: in_ready = 0. Shift left by 1 per cycle and decrement the counter. When the counter reaches 0, write outputs, set out_valid, and return to IDLE.
- flush has priority over accept and completion. In IDLE it blocks the accept. In SHIFT it aborts: return to IDLE, out_valid = 0, result registers unchanged. rst has priority over flush.
- No downstream backpressure: out_valid is a one-cycle pulse per completed operation.

## Timing
- Reset values: out_valid 0, result 0, zero 1, out_dst_reg 0, out_reg_write 0, illegal_op 0, state IDLE, in_ready 1 on the cycle after reset.
- Single-cycle ops: accept at edge N, out_valid = 1 in the cycle after edge N.
- Iterative sll with shift amount s (s ≥ 1): accept at edge N. The final shift is performed at edge N+s, and out_valid = 1 in the cycle after edge N+s (s+1 edges from acceptance to the result becoming visible). in_ready is low in the cycles after edges N … N+s−1 and returns high in the cycle after edge N+s, so a new operation can be accepted at edge N+s+1 while the sll result is on the outputs.
- Back-to-back single-cycle ops: one accept per cycle, out_valid held high continuously.
- in_ready is a function of state only and has no combinational path from in_valid.
- Reset asserted mid-shift returns the block to IDLE at the next edge with all outputs at their reset values.

## Configuration
- ALU_ITER_SHIFT_EN defined: sll uses the 1-bit-per-cycle iterative shifter, giving a latency of shamt+1 edges as described above.
- Not defined: sll uses a combinational barrel shift and completes in 1 cycle. The SHIFT state is unreachable and in_ready is always 1 outside reset.

## Structure
- Shared package alu_pkg holds the localparams for the op codes (ALU_AND=0, ALU_OR=1, ALU_ADD=2, ALU_SUB=3, ALU_SLL=4, ALU_SLT=5), the FSM state encoding, and the default WIDTH. The ALU control decoder uses the same package.
- One sub-module, alu_shift_unit, contains the shift register, counter and done flag, or the barrel shift depending on the macro.

## Test plan
- After reset: out_valid 0, zero 1, in_ready 1. Then op 2, src_a 5, src_b 7 -> next cycle out_valid 1, result 12, zero 0.
- op 3, src_a 9, src_b 9 -> result 0, zero 1. op 5, src_a 0xFFFFFFFF, src_b 1 -> result 1 (signed compare).
- With the macro defined: op 4, src_b 0x1, shamt 4 -> in_ready low for 4 cycles, out_valid pulses once with result 0x10. shamt 0 -> 1-cycle completion with result = src_b.
- op 9, reg_write 1 -> illegal_op 1, out_reg_write 0, result 0, out_valid 1.
- sll with shamt 31, flush asserted in the third SHIFT cycle -> no out_valid pulse, in_ready 1 on the next cycle. Next, op 0 with 0xF0F0 and 0x00FF -> result 0x00F0.
- Reset asserted mid-shift -> all outputs at reset values after the next edge, and no stale out_valid afterwards.
